f_fetch_stage: RTL and testbench
================================

// Module: f_fetch_stage
// PURPOSE
//  F-stage PC register and F/D pipeline register of the 5-stage MIPS core. Holds F_pc, drives the
//  instruction-memory handshake and loads next_pc from D-stage NPC logic. Buffers returned words
//  while D is stalled and delivers {pc, instr, valid} to D, with bubble and redirect handling.
// PARAMETERS
//  RESET_PC  32'h0000_3000  F_pc value after reset
//  IM_LO     32'h0000_3000  lowest legal fetch address (FETCH_EXC_EN only)
//  IM_HI     32'h0000_6FFC  highest legal fetch address (FETCH_EXC_EN only)
// PORTS
//  clk          in   1   clock; rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  stall        in   1   hazard unit: freeze F_pc and F/D register
//  next_pc      in   32  next PC from D-stage NPC (F_pc+4 or branch/jump target)
//  flush        in   1   exception/eret redirect: kill F and D contents
//  redirect_pc  in   32  PC loaded when flush=1
//  imem_addr    out  32  fetch address; stable while a request is outstanding
//  imem_req     out  1   fetch request
//  imem_ready   in   1   imem_rdata valid for imem_addr this cycle
//  imem_rdata   in   32  instruction word
//  F_pc         out  32  current fetch PC (to NPC as F_pc)
//  f_busy       out  1   fetch incomplete; hazard unit ORs it into stall
//  D_pc         out  32  PC of instruction in D
//  D_instr      out  32  instruction in D (32'h0 = nop when bubble)
//  D_valid      out  1   D holds a real instruction
// BEHAVIOUR
//  - Reset (async, reset_n=0): F_pc=RESET_PC, state=FETCH, hold_valid=0, D_pc=RESET_PC,
//    D_instr=0, D_valid=0, D_exc=0; imem_req=0 while in reset, 1 afterwards.
//  - States: FETCH (request outstanding), HOLD (word buffered, waiting on stall), DROP (redirect
//    issued while a request is outstanding; next response is discarded).
//  - word_ok = (state==FETCH && imem_ready) || state==HOLD; word = HOLD ? hold_instr : imem_rdata.
//  - f_busy = !word_ok || state==DROP. advance = word_ok && !stall && !flush.
//  - advance: F_pc<=next_pc; D_pc<=F_pc; D_instr<=word; D_valid<=1; state->FETCH. Latency: a word
//    returned in cycle n with stall=0 is visible on D_* in cycle n+1.
//  - word_ok && stall && !flush: F_pc and D_* hold; FETCH->HOLD latches imem_rdata; HOLD stays.
//  - !word_ok && !flush: F_pc and D_* hold (D kept so the branch in D keeps next_pc valid).
//  - flush (highest priority, overrides stall): D_instr<=0, D_valid<=0, D_pc<=redirect_pc,
//    F_pc<=redirect_pc, hold_valid<=0. If state==FETCH && !imem_ready, go DROP, else FETCH.
//  - DROP: imem_addr=drop_addr (old F_pc latched at flush); on imem_ready discard data, go FETCH.
//    A flush while in DROP updates F_pc only; drop_addr is unchanged.
//  - imem_addr=F_pc outside DROP. In HOLD imem_req=0; it reasserts on leaving HOLD.
//  - PC arithmetic is 32-bit modular; F_pc=32'hFFFF_FFFC with next_pc=F_pc+4 wraps to 0.
//  - Delay slot: no squash on branches; only flush kills the F/D contents.
// CONFIGURATION
//  FETCH_EXC_EN defined: fetch is AdEL when F_pc[1:0]!=0 or F_pc<IM_LO or F_pc>IM_HI.
//    - Such a fetch completes at once, without imem_req/imem_ready.
//    - Loads D_instr=0, D_valid=1 and adds output D_exc (5 bits, 5'd4 = AdEL).
//    - D_exc is 0 for normal fetches and is cleared by flush.
//  FETCH_EXC_EN undefined: no D_exc port; any address is fetched via the handshake.
// STRUCTURE
//  - Shared package cpu_pkg: RESET_PC, EXC_ADEL=5'd4, NOP=32'h0, fetch_state_t {FETCH,HOLD,DROP}.
//  - One sub-module fd_reg holds D_pc/D_instr/D_valid/D_exc, with load/bubble/hold controls.
//    State machine and PC register stay in the top.
// TESTING
//  - Reset: reset_n=0 mid-run -> F_pc=0x3000, D_valid=0, D_instr=0 the same cycle, without waiting for clk.
//  - Stream: imem_ready=1 always, next_pc=F_pc+4 -> D_pc 0x3000,0x3004,0x3008 on consecutive cycles.
//  - Slow mem: imem_ready after 3 cycles -> f_busy=1 for 3 cycles, F_pc=0x3000 held, D held, then D_pc=0x3000.
//  - Stall+buffer: word 0x2408_0001 returned while stall=1 for 2 cycles -> HOLD, imem_req=0;
//    D_instr=0x2408_0001 one cycle after release.
//  - Redirect: flush, redirect_pc=0x4180, request outstanding -> DROP, imem_addr stays old address,
//    stale word discarded; next D_pc=0x4180.
//  - FETCH_EXC_EN: next_pc=0x3002 -> D_exc=4, D_instr=0, D_valid=1, no imem_req for that fetch.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and fetch-state type shared by the F stage and the F/D register.
package cpu_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;
endpackage

// File: rtl/fd_reg.sv
// fd_reg: F/D pipeline register; bubble beats load, otherwise contents hold.
// FETCH_EXC_EN adds the exception-code field.
module fd_reg #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] bubble_pc_i,
`ifdef FETCH_EXC_EN
  input  logic [4:0]  exc_i,
  output logic [4:0]  exc_o,
`endif
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);
  import cpu_pkg::*;
  logic [31:0] pc_q, instr_q;
  logic        valid_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_q    <= bubble_pc_i;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
`ifdef FETCH_EXC_EN
  logic [4:0] exc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) exc_q <= 5'd0;
    else if (bubble_i) exc_q <= 5'd0;
    else if (load_i) exc_q <= exc_i;
  assign exc_o = exc_q;
`endif
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/f_fetch_stage.sv
// f_fetch_stage: F-stage PC register, imem handshake FSM and F/D register feed.
// FETCH_EXC_EN enables AdEL detection on fetch addresses and the D_exc output.
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
`ifdef FETCH_EXC_EN
  ,
  parameter logic [31:0] IM_LO = 32'h0000_3000,
  parameter logic [31:0] IM_HI = 32'h0000_6FFC
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic        f_busy,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
`ifdef FETCH_EXC_EN
  output logic [4:0]  D_exc,
`endif
  output logic        D_valid
);
  import cpu_pkg::*;
  fetch_state_t state_q, state_d;
  logic [31:0]  f_pc_q, f_pc_d, hold_q, hold_d, drop_q, drop_d, word;
  logic         adel, word_ok, advance;
`ifdef FETCH_EXC_EN
  assign adel = state_q == FETCH && (f_pc_q[1:0] != 2'b00 || f_pc_q < IM_LO || f_pc_q > IM_HI);
`else
  assign adel = 1'b0;
`endif
  assign word_ok = (state_q == FETCH && (imem_ready || adel)) || state_q == HOLD;
  assign advance = word_ok && !stall && !flush;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= FETCH;
      f_pc_q  <= RESET_PC;
      hold_q  <= NOP;
      drop_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      f_pc_q  <= f_pc_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  // An AdEL fetch never enters HOLD: it has no request and re-completes every cycle.
  always_comb begin
    state_d = flush ? ((((state_q == FETCH && !adel) || state_q == DROP) && !imem_ready) ? DROP : FETCH)
            : state_q == DROP ? (imem_ready ? FETCH : DROP)
            : (word_ok && stall && !adel) ? HOLD : FETCH;
    f_pc_d  = flush ? redirect_pc : advance ? next_pc : f_pc_q;
    hold_d  = state_q == FETCH ? imem_rdata : hold_q;
    drop_d  = (flush && state_q == FETCH) ? f_pc_q : drop_q;
  end
  always_comb begin
    imem_req  = reset_n && state_q != HOLD && !adel;
    imem_addr = state_q == DROP ? drop_q : f_pc_q;
    f_busy    = !word_ok || state_q == DROP;
    word      = state_q == HOLD ? hold_q : adel ? NOP : imem_rdata;
  end
  assign F_pc = f_pc_q;
  fd_reg #(.RESET_PC(RESET_PC)) u_fd (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (advance),
    .bubble_i   (flush),
    .pc_i       (f_pc_q),
    .instr_i    (word),
    .bubble_pc_i(redirect_pc),
`ifdef FETCH_EXC_EN
    .exc_i      (adel ? EXC_ADEL : 5'd0),
    .exc_o      (D_exc),
`endif
    .pc_o       (D_pc),
    .instr_o    (D_instr),
    .valid_o    (D_valid)
  );
endmodule

// File: tb/tb_f_fetch_stage.sv
// tb_f_fetch_stage: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_f_fetch_stage;
  logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0, flush = 1'b0, imem_ready = 1'b0;
  logic [31:0] next_pc = '0, redirect_pc = '0, imem_rdata = '0;
  logic [31:0] imem_addr, F_pc, D_pc, D_instr;
  logic        imem_req, f_busy, D_valid;
`ifdef FETCH_EXC_EN
  logic [4:0]  D_exc;
`endif
  int checks = 0, failures = 0;
  // Model: fetch PC, D contents, at most one buffered word, and a pending stale response.
  logic [31:0] m_pc, m_dpc, m_dinstr, m_buf, m_drop;
  logic [4:0]  m_dexc;
  bit          m_dvalid, m_bufv, m_disc;

  f_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .next_pc(next_pc), .flush(flush),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .F_pc(F_pc), .f_busy(f_busy),
    .D_pc(D_pc), .D_instr(D_instr),
`ifdef FETCH_EXC_EN
    .D_exc(D_exc),
`endif
    .D_valid(D_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2408_0000 + ((a - 32'h3000) >> 2) + 32'd1;
  endfunction

  function automatic bit bad(input logic [31:0] a);
`ifdef FETCH_EXC_EN
    return a[1:0] != 2'b00 || a < 32'h3000 || a > 32'h6FFC;
`else
    return a == 32'h0 && a != 32'h0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_F_pc", F_pc, 32'h3000);
    chk("rst_D_valid", {31'b0, D_valid}, 32'd0);
    chk("rst_D_instr", D_instr, 32'h0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    m_pc = 32'h3000; m_dpc = 32'h3000; m_dinstr = 0; m_dvalid = 0; m_bufv = 0; m_disc = 0; m_dexc = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called just after a falling edge: drive, compare, advance the model across the next rising edge.
  task automatic step(input bit st, input bit fl, input bit rdy, input logic [31:0] rpc,
                      input bit usen, input logic [31:0] npc);
    logic [31:0] addr, w;
    bit have, adel, got;
    have = m_bufv;
    adel = !m_disc && !have && bad(m_pc);
    got  = !m_disc && !have && (rdy || adel);
    addr = m_disc ? m_drop : m_pc;
    stall = st; flush = fl; redirect_pc = rpc; imem_ready = rdy;
    next_pc = usen ? npc : m_pc + 32'd4;
    imem_rdata = rdy ? mem(addr) : $urandom;
    #1;
    chk("F_pc", F_pc, m_pc);
    chk("D_pc", D_pc, m_dpc);
    chk("D_instr", D_instr, m_dinstr);
    chk("D_valid", {31'b0, D_valid}, {31'b0, m_dvalid});
    chk("imem_addr", imem_addr, addr);
    chk("imem_req", {31'b0, imem_req}, {31'b0, !have && !adel});
    chk("f_busy", {31'b0, f_busy}, {31'b0, !(have || got)});
`ifdef FETCH_EXC_EN
    chk("D_exc", {27'b0, D_exc}, {27'b0, m_dexc});
`endif
    w = have ? m_buf : adel ? 32'h0 : mem(m_pc);
    if (fl) begin
      if (m_disc) m_disc = !rdy;
      else if (!have && !adel && !rdy) begin m_disc = 1; m_drop = m_pc; end
      m_bufv = 0; m_pc = rpc; m_dpc = rpc; m_dinstr = 0; m_dvalid = 0; m_dexc = 0;
    end else if (m_disc) m_disc = !rdy;
    else if ((have || got) && !st) begin
      m_dpc = m_pc; m_dinstr = w; m_dvalid = 1; m_dexc = adel ? 5'd4 : 5'd0;
      m_pc = next_pc; m_bufv = 0;
    end else if (got && !adel) begin
      m_bufv = 1; m_buf = w;
    end
    @(negedge clk);
  endtask

  task automatic rnd(input int n);
    logic [31:0] t, u;
    for (int i = 0; i < n; i++) begin
      t = ($urandom % 5 == 0) ? $urandom : 32'h3000 + ($urandom % 4096) * 4;
      u = ($urandom % 5 == 0) ? $urandom : 32'h3000 + ($urandom % 4096) * 4;
      step($urandom % 4 == 0, $urandom % 20 == 0, $urandom % 2 == 0, t, $urandom % 6 == 0, u);
    end
  endtask

  initial begin
    do_reset();
    step(0, 0, 1, 0, 0, 0); chk("stream0", D_pc, 32'h3000);
    step(0, 0, 1, 0, 0, 0); chk("stream1", D_pc, 32'h3004);
    step(0, 0, 1, 0, 0, 0); chk("stream2", D_pc, 32'h3008);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("slow_busy", {31'b0, f_busy}, 32'd1);
      chk("slow_F_pc", F_pc, 32'h3000);
      chk("slow_D_valid", {31'b0, D_valid}, 32'd0);
    end
    step(0, 0, 1, 0, 0, 0);
    chk("slow_D_pc", D_pc, 32'h3000);
    chk("slow_D_valid_after", {31'b0, D_valid}, 32'd1);
    do_reset();
    step(1, 0, 1, 0, 0, 0); chk("hold_req0", {31'b0, imem_req}, 32'd0);
    step(1, 0, 0, 0, 0, 0); chk("hold_req1", {31'b0, imem_req}, 32'd0);
    chk("hold_D_valid", {31'b0, D_valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_D_instr", D_instr, 32'h2408_0001);
    chk("hold_F_pc", F_pc, 32'h3004);
    chk("hold_req_back", {31'b0, imem_req}, 32'd1);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h4180, 0, 0);
    chk("drop_addr0", imem_addr, 32'h3000);
    chk("drop_F_pc", F_pc, 32'h4180);
    chk("drop_D_pc", D_pc, 32'h4180);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_addr1", imem_addr, 32'h3000);
    chk("drop_busy", {31'b0, f_busy}, 32'd1);
    step(0, 0, 1, 0, 0, 0);
    chk("drop_discard", {31'b0, D_valid}, 32'd0);
    chk("drop_new_addr", imem_addr, 32'h4180);
    step(0, 0, 1, 0, 0, 0);
    chk("redir_D_pc", D_pc, 32'h4180);
    chk("redir_D_instr", D_instr, 32'h2408_0461);
    step(0, 1, 0, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("wrap_F_pc", F_pc, 32'h0);
    chk("wrap_D_pc", D_pc, 32'hFFFF_FFFC);
`ifdef FETCH_EXC_EN
    do_reset();
    step(0, 0, 1, 0, 1, 32'h3002);
    chk("adel_F_pc", F_pc, 32'h3002);
    chk("adel_no_req", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("adel_D_exc", {27'b0, D_exc}, 32'd4);
    chk("adel_D_instr", D_instr, 32'h0);
    chk("adel_D_valid", {31'b0, D_valid}, 32'd1);
`endif
    rnd(3000);
    do_reset();
    rnd(1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
